// File: rtl/pipe_stall_flush_ctrl.sv
// rtl/pipe_stall_flush_ctrl.sv - per-register stall/flush generator with pending-redirect FSM and perf counters
module pipe_stall_flush_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int EX_STAGE   = 2,
    parameter int MEM_STAGE  = 3,
    parameter int MODE       = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iwait,
    input  logic                  dwait,
    input  logic                  ex_busy,
    input  logic                  load_use,
    input  logic                  redirect,
    input  logic                  clr_perf,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  pc_redirect,
    output logic                  redirect_pending,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      redirect_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    function automatic logic [NUM_STAGES-1:0] span(input int lo, input int hi);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] DW_STALL     = span(0, MEM_STAGE);
    localparam logic [NUM_STAGES-1:0] DW_FLUSH     = span(MEM_STAGE + 1, MEM_STAGE + 1);
    localparam logic [NUM_STAGES-1:0] EB_STALL     = span(0, EX_STAGE);
    localparam logic [NUM_STAGES-1:0] EB_FLUSH     = span(EX_STAGE + 1, EX_STAGE + 1);
    localparam logic [NUM_STAGES-1:0] SQUASH_FLUSH = span(1, EX_STAGE);
    localparam logic [NUM_STAGES-1:0] LU_STALL     = span(0, 1);
    localparam logic [NUM_STAGES-1:0] LU_FLUSH     = span(2, 2);
    localparam logic [NUM_STAGES-1:0] PC_ONLY      = span(0, 0);
    localparam logic [NUM_STAGES-1:0] IFID_ONLY    = span(1, 1);
    localparam logic [NUM_STAGES-1:0] GLOBAL_STALL = span(0, NUM_STAGES - 2);
    localparam logic [NUM_STAGES-1:0] LAST_MASK    = span(NUM_STAGES - 1, NUM_STAGES - 1);

    logic [0:0]            state, state_nxt;
    logic [NUM_STAGES-1:0] stall_raw, flush_raw;
    logic                  pc_redirect_raw;
    logic                  redirect_accept;

    always_comb begin
        stall_raw       = '0;
        flush_raw       = '0;
        pc_redirect_raw = 1'b0;
        redirect_accept = 1'b0;
        state_nxt       = state;
        if (MODE == 0) begin
            if (iwait || dwait || ex_busy) begin
                stall_raw = GLOBAL_STALL;
            end else if (redirect) begin
                pc_redirect_raw = 1'b1;
                flush_raw       = SQUASH_FLUSH;
                redirect_accept = 1'b1;
            end else if (load_use) begin
                stall_raw = LU_STALL;
                flush_raw = LU_FLUSH;
            end
        end else if (dwait) begin
            stall_raw = DW_STALL;
            flush_raw = DW_FLUSH;
        end else if (ex_busy) begin
            stall_raw = EB_STALL;
            flush_raw = EB_FLUSH;
        end else if (state == PEND) begin
            // Younger instructions are already squashed; only the fetch matters.
            flush_raw = IFID_ONLY;
            if (iwait) begin
                stall_raw = PC_ONLY;
            end else begin
                pc_redirect_raw = 1'b1;
                state_nxt       = IDLE;
            end
        end else if (redirect) begin
            flush_raw       = SQUASH_FLUSH;
            redirect_accept = 1'b1;
            if (iwait) begin
                stall_raw = PC_ONLY;
                state_nxt = PEND;
            end else begin
                pc_redirect_raw = 1'b1;
            end
        end else if (load_use) begin
            stall_raw = LU_STALL;
            flush_raw = LU_FLUSH;
        end else if (iwait) begin
            stall_raw = PC_ONLY;
            flush_raw = IFID_ONLY;
        end
    end

    assign stall            = reset ? '0 : (stall_raw & ~LAST_MASK);
    assign flush            = reset ? '0 : (flush_raw & ~stall_raw);
    assign pc_redirect      = !reset && pc_redirect_raw;
    assign redirect_pending = !reset && (state == PEND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            state <= state_nxt;
            if (clr_perf) begin
                stall_cycles   <= '0;
                redirect_count <= '0;
            end else begin
                if (stall[0] && stall_cycles != '1)
                    stall_cycles <= stall_cycles + CNT_W'(1);
                if (redirect_accept && redirect_count != '1)
                    redirect_count <= redirect_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// tb/tb_pipe_stall_flush_ctrl.sv - self-checking bench for pipe_stall_flush_ctrl
module tb_pipe_stall_flush_ctrl;

    logic clk = 1'b0;
    logic reset, iwait, dwait, ex_busy, load_use, redirect, clr_perf;

    logic [4:0]  m1_stall, m1_flush, m0_stall, m0_flush, c2_stall, c2_flush;
    logic        m1_pcr, m1_pend, m0_pcr, m0_pend, c2_pcr, c2_pend;
    logic [15:0] m1_sc, m1_rc, m0_sc, m0_rc;
    logic [1:0]  c2_sc, c2_rc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stall_flush_ctrl u_m1 (
        .clk(clk), .reset(reset), .iwait(iwait), .dwait(dwait), .ex_busy(ex_busy),
        .load_use(load_use), .redirect(redirect), .clr_perf(clr_perf),
        .stall(m1_stall), .flush(m1_flush), .pc_redirect(m1_pcr),
        .redirect_pending(m1_pend), .stall_cycles(m1_sc), .redirect_count(m1_rc));

    pipe_stall_flush_ctrl #(.MODE(0)) u_m0 (
        .clk(clk), .reset(reset), .iwait(iwait), .dwait(dwait), .ex_busy(ex_busy),
        .load_use(load_use), .redirect(redirect), .clr_perf(clr_perf),
        .stall(m0_stall), .flush(m0_flush), .pc_redirect(m0_pcr),
        .redirect_pending(m0_pend), .stall_cycles(m0_sc), .redirect_count(m0_rc));

    pipe_stall_flush_ctrl #(.CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .iwait(iwait), .dwait(dwait), .ex_busy(ex_busy),
        .load_use(load_use), .redirect(redirect), .clr_perf(clr_perf),
        .stall(c2_stall), .flush(c2_flush), .pc_redirect(c2_pcr),
        .redirect_pending(c2_pend), .stall_cycles(c2_sc), .redirect_count(c2_rc));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [4:0] st;
        logic [4:0] fl;
        logic       pcr;
        logic       pend_o;
        logic       nxt;
        logic       rinc;
    } exp_t;

    function automatic logic [4:0] bits(input int lo, input int hi);
        logic [4:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Reference rules for the default geometry: EX=2, MEM=3, five registers.
    function automatic exp_t model(input bit mode, input bit pend, input bit iw, input bit dw,
                                   input bit eb, input bit lu, input bit rd);
        exp_t e = '0;
        if (!mode) begin
            if (iw || dw || eb) e.st = bits(0, 3);
            else if (rd) begin e.pcr = 1; e.fl = bits(1, 2); e.rinc = 1; end
            else if (lu) begin e.st = bits(0, 1); e.fl = bits(2, 2); end
        end else begin
            e.pend_o = pend;
            e.nxt    = pend;
            if (dw)      begin e.st = bits(0, 3); e.fl = bits(4, 4); end
            else if (eb) begin e.st = bits(0, 2); e.fl = bits(3, 3); end
            else if (pend) begin
                e.fl = bits(1, 1);
                if (iw) e.st = bits(0, 0);
                else begin e.pcr = 1; e.nxt = 0; end
            end else if (rd) begin
                e.fl = bits(1, 2);
                e.rinc = 1;
                if (iw) begin e.st = bits(0, 0); e.nxt = 1; end
                else e.pcr = 1;
            end else if (lu) begin e.st = bits(0, 1); e.fl = bits(2, 2); end
            else if (iw) begin e.st = bits(0, 0); e.fl = bits(1, 1); end
        end
        return e;
    endfunction

    function automatic int sat_next(input int v, input bit inc, input bit clr, input int max);
        if (clr) return 0;
        if (inc && v < max) return v + 1;
        return v;
    endfunction

    bit pend_m = 0;
    int sc16 = 0, rc16 = 0, sc0 = 0, rc0 = 0, sc2 = 0, rc2 = 0;
    bit cmp_en = 0;

    always @(posedge clk or posedge reset) begin
        exp_t e1, e0;
        if (reset) begin
            pend_m = 0;
            sc16 = 0; rc16 = 0; sc0 = 0; rc0 = 0; sc2 = 0; rc2 = 0;
        end else begin
            e1 = model(1, pend_m, iwait, dwait, ex_busy, load_use, redirect);
            e0 = model(0, 0, iwait, dwait, ex_busy, load_use, redirect);
            pend_m = e1.nxt;
            sc16 = sat_next(sc16, e1.st[0], clr_perf, 65535);
            rc16 = sat_next(rc16, e1.rinc, clr_perf, 65535);
            sc2  = sat_next(sc2, e1.st[0], clr_perf, 3);
            rc2  = sat_next(rc2, e1.rinc, clr_perf, 3);
            sc0  = sat_next(sc0, e0.st[0], clr_perf, 65535);
            rc0  = sat_next(rc0, e0.rinc, clr_perf, 65535);
        end
    end

    always @(negedge clk) begin
        exp_t e1, e0;
        if (cmp_en) begin
            e1 = reset ? '0 : model(1, pend_m, iwait, dwait, ex_busy, load_use, redirect);
            e0 = reset ? '0 : model(0, 0, iwait, dwait, ex_busy, load_use, redirect);
            chk("m1_stall", m1_stall, e1.st);
            chk("m1_flush", m1_flush, e1.fl);
            chk("m1_pc_redirect", m1_pcr, e1.pcr);
            chk("m1_pending", m1_pend, e1.pend_o);
            chk("m1_stall_cycles", m1_sc, sc16);
            chk("m1_redirect_count", m1_rc, rc16);
            chk("m0_stall", m0_stall, e0.st);
            chk("m0_flush", m0_flush, e0.fl);
            chk("m0_pc_redirect", m0_pcr, e0.pcr);
            chk("m0_pending", m0_pend, 0);
            chk("m0_stall_cycles", m0_sc, sc0);
            chk("m0_redirect_count", m0_rc, rc0);
            chk("c2_stall", c2_stall, e1.st);
            chk("c2_flush", c2_flush, e1.fl);
            chk("c2_stall_cycles", c2_sc, sc2);
            chk("c2_redirect_count", c2_rc, rc2);
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        iwait = 0; dwait = 0; ex_busy = 0; load_use = 0; redirect = 0; clr_perf = 0;
    endtask

    initial begin
        reset = 1;
        quiet();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        cmp_en = 1;
        @(negedge clk);
        chk("lit_quiet_stall", m1_stall, 5'b00000);
        chk("lit_quiet_sc", m1_sc, 0);
        nxt();

        iwait = 1;
        repeat (3) begin
            @(negedge clk);
            chk("lit_iwait_stall", m1_stall, 5'b00001);
            chk("lit_iwait_flush", m1_flush, 5'b00010);
            nxt();
        end
        iwait = 0;
        @(negedge clk);
        chk("lit_stall_cycles_3", m1_sc, 3);
        nxt();

        dwait = 1;
        repeat (2) begin
            @(negedge clk);
            chk("lit_dwait_stall", m1_stall, 5'b01111);
            chk("lit_dwait_flush", m1_flush, 5'b10000);
            nxt();
        end
        dwait = 0;

        redirect = 1; iwait = 1;
        @(negedge clk);
        chk("lit_redir_iw_stall", m1_stall, 5'b00001);
        chk("lit_redir_iw_flush", m1_flush, 5'b00110);
        chk("lit_redir_iw_pend", m1_pend, 0);
        nxt();
        redirect = 0;
        repeat (2) begin
            @(negedge clk);
            chk("lit_pend_stall", m1_stall, 5'b00001);
            chk("lit_pend_flush", m1_flush, 5'b00010);
            chk("lit_pend_flag", m1_pend, 1);
            nxt();
        end
        iwait = 0;
        @(negedge clk);
        chk("lit_pend_release_pcr", m1_pcr, 1);
        nxt();
        @(negedge clk);
        chk("lit_idle_pend", m1_pend, 0);
        chk("lit_idle_pcr", m1_pcr, 0);
        chk("lit_redirect_count_1", m1_rc, 1);
        nxt();

        load_use = 1; iwait = 1;
        @(negedge clk);
        chk("lit_lu_stall", m1_stall, 5'b00011);
        chk("lit_lu_flush", m1_flush, 5'b00100);
        nxt();
        load_use = 0; iwait = 0;

        dwait = 1; ex_busy = 1; redirect = 1;
        @(negedge clk);
        chk("lit_backend_stall", m1_stall, 5'b01111);
        chk("lit_backend_flush", m1_flush, 5'b10000);
        chk("lit_backend_pcr", m1_pcr, 0);
        nxt();
        quiet();
        @(negedge clk);
        chk("lit_backend_rc", m1_rc, 1);
        nxt();

        iwait = 1; redirect = 1;
        @(negedge clk);
        chk("lit_m0_stall", m0_stall, 5'b01111);
        chk("lit_m0_flush", m0_flush, 5'b00000);
        chk("lit_m0_pcr", m0_pcr, 0);
        nxt();
        iwait = 0;
        @(negedge clk);
        chk("lit_m0_release_pcr", m0_pcr, 1);
        chk("lit_m0_release_flush", m0_flush, 5'b00110);
        nxt();
        quiet();
        nxt();

        clr_perf = 1; iwait = 1;
        nxt();
        clr_perf = 0;
        @(negedge clk);
        chk("lit_clr_c2", c2_sc, 0);
        chk("lit_clr_m1", m1_sc, 0);
        repeat (5) nxt();
        iwait = 0;
        @(negedge clk);
        chk("lit_sat_c2", c2_sc, 3);
        chk("lit_nosat_m1", m1_sc, 5);
        nxt();

        redirect = 1; iwait = 1;
        nxt();
        redirect = 0;
        @(negedge clk);
        chk("lit_pre_reset_pend", m1_pend, 1);
        #2 reset = 1;
        #1;
        chk("lit_async_stall", m1_stall, 5'b00000);
        chk("lit_async_flush", m1_flush, 5'b00000);
        chk("lit_async_pend", m1_pend, 0);
        nxt();
        quiet();
        reset = 0;
        repeat (2) begin
            @(negedge clk);
            chk("lit_post_reset_stall", m1_stall, 5'b00000);
            chk("lit_post_reset_pcr", m1_pcr, 0);
            chk("lit_post_reset_sc", m1_sc, 0);
            chk("lit_post_reset_rc", m1_rc, 0);
            nxt();
        end

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_flush_ctrl.md
Name: pipe_stall_flush_ctrl

Overview:
- Parametrised successor to the pipeline stall generator for the LC-3b pipeline.
- Outputs per-register stall (hold) and flush (load bubble) vectors, so only the stages that must freeze actually freeze.
- Adds load-use bubbles, a branch/jump redirect squash, a pending-redirect FSM for when a redirect arrives during an outstanding I-fetch, and saturating performance counters.
- Sits beside the datapath and drives the enables and NOP-selects of the PC and inter-stage registers.

Parameters:
- NUM_STAGES, 5, number of pipeline registers including the PC. Index 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB.
- EX_STAGE, 2, index of the register feeding the stage that resolves redirects and runs multicycle ops.
- MEM_STAGE, 3, index of the register feeding the data-memory stage.
- MODE, 1, selects freeze policy: 0 = global freeze on any wait (legacy), 1 = selective.
- CNT_W, 16, width of each performance counter.
- Legal values: NUM_STAGES >= 4; 1 <= EX_STAGE < MEM_STAGE <= NUM_STAGES-2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- iwait  in  1  I-memory access outstanding.
- dwait  in  1  D-memory access outstanding.
- ex_busy  in  1  multicycle EX unit not done.
- load_use  in  1  decode instruction needs the result of the load currently in EX.
- redirect  in  1  taken branch, JMP or TRAP resolved in EX this cycle.
- clr_perf  in  1  synchronous clear of both counters.
- stall  out  NUM_STAGES  1 = register i holds its value.
- flush  out  NUM_STAGES  1 = register i loads a bubble.
- pc_redirect  out  1  PC loads the redirect target this cycle.
- redirect_pending  out  1  FSM is in PEND.
- stall_cycles  out  CNT_W  count of cycles with stall[0]=1.
- redirect_count  out  CNT_W  count of accepted redirects.

Behaviour:
- Clock and reset: reset is asynchronous and active-high. The clock port is clk and the reset port is reset.
- Reset: FSM goes to IDLE and both counters go to 0. While reset is high, stall, flush, pc_redirect and redirect_pending are all 0.
- Output structure: outputs are combinational from the inputs and FSM state, with zero latency. stall[i] and flush[i] are never both 1; stall wins. stall[NUM_STAGES-1] is always 0.
- FSM state IDLE, priority order in MODE=1 (first matching rule applies):
  1. Backend wait. dwait: stall[0..MEM_STAGE]=1, flush[MEM_STAGE+1]=1. Otherwise, if ex_busy: stall[0..EX_STAGE]=1, flush[EX_STAGE+1]=1. If both are high, the dwait pattern applies. Redirect and load_use are ignored; the datapath holds them asserted.
  2. redirect with iwait=0: pc_redirect=1, flush[1..EX_STAGE]=1, redirect_count increments.
  3. redirect with iwait=1: stall[0]=1, flush[1..EX_STAGE]=1, redirect_count increments, next state is PEND.
  4. load_use: stall[0..1]=1, flush[2]=1, regardless of iwait.
  5. iwait alone: stall[0]=1, flush[1]=1.
  6. Otherwise all outputs are 0.
- FSM state PEND:
  - redirect_pending=1.
  - Backend wait takes priority exactly as in rule 1, and the FSM stays in PEND.
  - Else, if iwait=1: stall[0]=1, flush[1]=1.
  - Else, if iwait=0: pc_redirect=1, flush[1]=1, next state is IDLE.
  - redirect and load_use are ignored in PEND, because the younger instructions were squashed.
- MODE=0:
  - Any of iwait, dwait or ex_busy gives stall[0..NUM_STAGES-2]=1 with all flush bits 0.
  - Otherwise rules 2 and 4 apply.
  - PEND is never entered.
- Counters:
  - Both counters saturate at all-ones.
  - clr_perf takes precedence over an increment in the same cycle.
  - Reset mid-PEND discards the pending redirect.

Test Plan:
- Reset: reset=1 mid-PEND with iwait=1 -> stall=0, flush=0, redirect_pending=0 immediately (asynchronous). After release with quiet inputs, all outputs stay 0 and counters read 0.
- iwait=1 for 3 cycles (MODE=1) -> stall=5'b00001, flush=5'b00010 each cycle, stall_cycles=3. dwait=1 for 2 cycles -> stall=5'b01111, flush=5'b10000.
- redirect=1 with iwait=1, then iwait held 2 more cycles -> first cycle stall=5'b00001, flush=5'b00110, redirect_pending rises. Then 2 cycles of stall=5'b00001, flush=5'b00010. When iwait=0: pc_redirect=1 for one cycle, then IDLE, redirect_count=1.
- load_use=1 with iwait=1 -> stall=5'b00011, flush=5'b00100. dwait=1 with ex_busy=1 and redirect=1 -> stall=5'b01111, flush=5'b10000, pc_redirect=0, redirect_count unchanged.
- MODE=0, iwait=1 and redirect=1 -> stall=5'b01111, flush=0, pc_redirect=0. When iwait drops with redirect still high: pc_redirect=1, flush=5'b00110.
- CNT_W=2 with iwait=1 for 5 cycles -> stall_cycles saturates at 3. clr_perf=1 with iwait=1 -> next value is 0.
